// File: rtl/ofifo_deskew.sv
// ofifo_deskew: output-side de-skew collector for the systolic array.
//
// Each array column is buffered in its own circular lane.
// Columns may arrive skewed by any number of cycles.
// A full row is released only when every lane holds at least one entry.
// The row is then popped from all lanes together, so alignment follows
// per-lane FIFO order.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears pointers, out and o_ovf
//   in         column data, lane i in in[(i+1)*bw-1 : i*bw]
//   wr         per-lane write strobe
//   rd         pop one aligned row; ignored while o_valid is low
//   flush_ptr  discard all buffered contents and clear o_ovf
//   out        registered popped row, same lane slicing as in
//   o_valid    every lane non-empty (combinational from the pointers)
//   o_full     at least one lane full (combinational from the pointers)
//   o_ready    inverse of o_full
//   o_ovf      sticky: a write was dropped on a full lane
module ofifo_deskew #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [col*bw-1:0]   in,
    input  logic [col-1:0]      wr,
    input  logic                rd,
    input  logic                flush_ptr,
    output logic [col*bw-1:0]   out,
    output logic                o_valid,
    output logic                o_full,
    output logic                o_ready,
    output logic                o_ovf
);

    // Address bits per lane; pointers carry one extra wrap bit.
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;

    logic [col-1:0]      empty_s;
    logic [col-1:0]      full_s;
    logic [col-1:0]      wr_en_s;
    logic [col-1:0]      drop_s;
    logic                valid_s;
    logic                rd_en_s;
    logic                clear_s;
    logic [col*bw-1:0]   head_s;
    logic [col*bw-1:0]   out_r;
    logic                ovf_r;

    // Reset and flush both zero every pointer.
    // A lane cannot be read or written in a cycle where they are zeroed.
    assign clear_s = reset | flush_ptr;

    // Row availability and aggregate fullness
    always_comb begin
        valid_s = &(~empty_s);
        o_valid = valid_s;
        o_full  = |full_s;
        o_ready = ~(|full_s);
    end

    // Pop and per-lane write/drop decisions.
    // A full lane that is popped in the same cycle has room after the pop,
    // so it accepts the write instead of dropping it.
    always_comb begin
        rd_en_s = 1'b0;
        wr_en_s = '0;
        drop_s  = '0;
        if (clear_s) begin
            rd_en_s = 1'b0;
        end else begin
            rd_en_s = rd & valid_s;
        end
        for (int i = 0; i < col; i++) begin
            if (clear_s) begin
                wr_en_s[i] = 1'b0;
                drop_s[i]  = 1'b0;
            end else begin
                wr_en_s[i] = wr[i] & (~full_s[i] | rd_en_s);
                drop_s[i]  = wr[i] & full_s[i] & ~rd_en_s;
            end
        end
    end

    for (genvar g = 0; g < col; g++) begin : g_lane
        logic [bw-1:0] mem_r [depth];
        logic [aw:0]   wptr_r;
        logic [aw:0]   rptr_r;

        // The lane is empty when the pointers match.
        // The lane is full when the addresses match and the wrap bits differ.
        assign empty_s[g] = (wptr_r == rptr_r);
        assign full_s[g]  = (wptr_r[aw-1:0] == rptr_r[aw-1:0]) &&
                            (wptr_r[aw] != rptr_r[aw]);
        assign head_s[g*bw +: bw] = mem_r[rptr_r[aw-1:0]];

        // Lane storage write; contents are never cleared, only the pointers
        always_ff @(posedge clk) begin
            if (wr_en_s[g]) begin
                mem_r[wptr_r[aw-1:0]] <= in[g*bw +: bw];
            end else begin
                mem_r[wptr_r[aw-1:0]] <= mem_r[wptr_r[aw-1:0]];
            end
        end

        // Lane pointer update, wrapping naturally modulo 2*depth
        always_ff @(posedge clk) begin
            if (clear_s) begin
                wptr_r <= '0;
                rptr_r <= '0;
            end else begin
                if (wr_en_s[g]) begin
                    wptr_r <= wptr_r + (aw+1)'(1);
                end else begin
                    wptr_r <= wptr_r;
                end
                if (rd_en_s) begin
                    rptr_r <= rptr_r + (aw+1)'(1);
                end else begin
                    rptr_r <= rptr_r;
                end
            end
        end
    end

    // Output row register and sticky overflow flag.
    // Flush clears the overflow flag but leaves out untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r <= '0;
            ovf_r <= 1'b0;
        end else if (flush_ptr) begin
            out_r <= out_r;
            ovf_r <= 1'b0;
        end else begin
            if (rd_en_s) begin
                out_r <= head_s;
            end else begin
                out_r <= out_r;
            end
            ovf_r <= ovf_r | (|drop_s);
        end
    end

    assign out   = out_r;
    assign o_ovf = ovf_r;

endmodule
